// File: rtl/sltu_pkg.sv
// sltu_pkg: shared word type and flag zero-extension for the SLTU result path
package sltu_pkg;
  localparam int XLEN = 32;
  typedef logic [XLEN-1:0] word_t;
  function automatic word_t sltu_flag(logic ge);
    return {{(XLEN-1){1'b0}}, ge};
  endfunction
endpackage

// File: rtl/sltu_borrow_chain.sv
// sltu_borrow_chain: borrow-out of a_i - b_i via nibble-grouped carry lookahead; ports a_i, b_i (WIDTH), borrow_o
module sltu_borrow_chain
  import sltu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             borrow_o
);
  localparam int NG = WIDTH / 4;
  logic [WIDTH-1:0] w_g;
  logic [WIDTH-1:0] w_p;
  logic [NG-1:0]    w_gg;
  logic [NG-1:0]    w_gp;
  logic [NG:0]      w_c;
  // carry terms of a + ~b + 1; carry-out set means no borrow
  assign w_g    = a_i & ~b_i;
  assign w_p    = a_i | ~b_i;
  assign w_c[0] = 1'b1;
  for (genvar i = 0; i < NG; i++) begin : g_grp
    assign w_gg[i] = w_g[4*i+3]
                   | (w_p[4*i+3] & w_g[4*i+2])
                   | (w_p[4*i+3] & w_p[4*i+2] & w_g[4*i+1])
                   | (w_p[4*i+3] & w_p[4*i+2] & w_p[4*i+1] & w_g[4*i]);
    assign w_gp[i]   = &w_p[4*i+:4];
    assign w_c[i+1]  = w_gg[i] | (w_gp[i] & w_c[i]);
  end
  assign borrow_o = ~w_c[NG];
endmodule

// File: rtl/set_less_than_unsigned.sv
// set_less_than_unsigned: unsigned compare, rd_o = {0.., rs1_i >= rs2_i}; ports clk_i, rst_i, rs1_i, rs2_i, rd_o; macro SLTU_OUT_REG_EN adds a 1-cycle output flop
module set_less_than_unsigned
  import sltu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] rs1_i,
  input  logic [WIDTH-1:0] rs2_i,
  output logic [WIDTH-1:0] rd_o
);
  logic             w_borrow;
  word_t            w_flag;
  logic [WIDTH-1:0] w_rd;
  sltu_borrow_chain #(.WIDTH(WIDTH)) u_chain (
    .a_i      (rs1_i),
    .b_i      (rs2_i),
    .borrow_o (w_borrow)
  );
  assign w_flag = sltu_flag(~w_borrow);
  assign w_rd   = WIDTH'(w_flag);
`ifdef SLTU_OUT_REG_EN
  logic [WIDTH-1:0] r_rd;
  always_ff @(posedge clk_i) r_rd <= rst_i ? '0 : w_rd;
  assign rd_o = r_rd;
`else
  logic w_unused;
  assign w_unused = &{1'b0, clk_i, rst_i};
  assign rd_o     = w_rd;
`endif
endmodule

// File: tb/tb_set_less_than_unsigned.sv
// tb_set_less_than_unsigned: vector table plus random pairs against an arithmetic model
module tb_set_less_than_unsigned;
  typedef struct {
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] exp;
  } vec_t;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] rs1 = '0;
  logic [31:0] rs2 = '0;
  logic [31:0] rd;
  int          n_vec = 0;
  int          n_bad = 0;
  vec_t        tbl[8];
  always #5 clk = ~clk;
  set_less_than_unsigned #(.WIDTH(32)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .rs1_i (rs1),
    .rs2_i (rs2),
    .rd_o  (rd)
  );
  function automatic logic [31:0] model(logic [31:0] a, logic [31:0] b);
    longint unsigned ua = 64'(a);
    longint unsigned ub = 64'(b);
    return (ua < ub) ? 32'd0 : 32'd1;
  endfunction
  task automatic check(string name, logic [31:0] exp);
    n_vec++;
    if (rd !== exp) begin
      n_bad++;
      $display("FAIL %s: rs1=%h rs2=%h rd_o=%h expected=%h", name, rs1, rs2, rd, exp);
    end
  endtask
  task automatic apply(string name, logic [31:0] a, logic [31:0] b, logic [31:0] exp);
    @(negedge clk);
    rs1 = a;
    rs2 = b;
`ifdef SLTU_OUT_REG_EN
    @(posedge clk);
`endif
    #1;
    check(name, exp);
  endtask
  initial begin
    tbl[0] = '{32'd5,          32'd7,          32'd0};
    tbl[1] = '{32'd7,          32'd5,          32'd1};
    tbl[2] = '{32'h1234_5678,  32'h1234_5678,  32'd1};
    tbl[3] = '{32'd0,          32'd0,          32'd1};
    tbl[4] = '{32'hFFFF_FFFF,  32'd1,          32'd1};
    tbl[5] = '{32'd1,          32'h8000_0000,  32'd0};
    tbl[6] = '{32'hFFFF_FFFE,  32'hFFFF_FFFF,  32'd0};
    tbl[7] = '{32'd0,          32'hFFFF_FFFF,  32'd0};
    rs1 = 32'd7;
    rs2 = 32'd5;
    repeat (2) @(posedge clk);
    #1;
`ifdef SLTU_OUT_REG_EN
    check("reset_hold", 32'd0);
`else
    check("comb_during_reset", 32'd1);
`endif
    @(negedge clk);
    rst = 1'b0;
`ifdef SLTU_OUT_REG_EN
    #1;
    check("before_first_edge", 32'd0);
    @(posedge clk);
    #1;
    check("one_edge_latency", 32'd1);
`endif
    for (int i = 0; i < 8; i++) apply($sformatf("table%0d", i), tbl[i].rs1, tbl[i].rs2, tbl[i].exp);
`ifdef SLTU_OUT_REG_EN
    @(negedge clk);
    rs1 = 32'd9;
    rs2 = 32'd3;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("mid_stream_reset", 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("after_reset_release", 32'd1);
`endif
    for (int i = 0; i < 100; i++) begin
      logic [31:0] a;
      logic [31:0] b;
      a = $urandom;
      b = (i % 10 == 0) ? a : $urandom;
      if (i % 7 == 3) b = a + 32'd1;
      apply($sformatf("rand%0d", i), a, b, model(a, b));
      repeat (4) @(negedge clk);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
